// File: rtl/rx_halfwave_meter_if.sv
// ---------------------------------------------------------------------------
// rx_halfwave_meter_if
//   Bundles the sample stream, runtime configuration and measurement results
//   of rx_halfwave_meter.
//   master : sample/config source (drives ce, din, exp_half, tol, clr_err)
//   slave  : the meter (drives RXP, RXN, AMP, half_per, N_RXPN, lock, err,
//            err_cnt)
// Signals
//   ce        sample strobe, din valid when high
//   din       W-bit ADC sample
//   exp_half  expected half-period in samples
//   tol       allowed |half_per - exp_half|
//   clr_err   synchronous clear of err_cnt
//   RXP/RXN   1-clk pulses on negative->positive / positive->negative crossing
//   AMP       peak |x| of the half-wave just completed
//   half_per  samples between the last two crossings (saturating)
//   N_RXPN    crossing count (wraps)
//   lock      high after the first crossing, dropped on loss of signal
//   err       1-clk pulse on period mismatch or loss of signal
//   err_cnt   saturating error count
// ---------------------------------------------------------------------------
interface rx_halfwave_meter_if #(
    parameter int W  = 12,
    parameter int PW = 12,
    parameter int NW = 8
);
    logic          ce;
    logic [W-1:0]  din;
    logic [PW-1:0] exp_half;
    logic [PW-1:0] tol;
    logic          clr_err;

    logic          RXP;
    logic          RXN;
    logic [W-2:0]  AMP;
    logic [PW-1:0] half_per;
    logic [NW-1:0] N_RXPN;
    logic          lock;
    logic          err;
    logic [7:0]    err_cnt;

    modport master (
        output ce, din, exp_half, tol, clr_err,
        input  RXP, RXN, AMP, half_per, N_RXPN, lock, err, err_cnt
    );

    modport slave (
        input  ce, din, exp_half, tol, clr_err,
        output RXP, RXN, AMP, half_per, N_RXPN, lock, err, err_cnt
    );
endinterface

// File: rtl/rx_halfwave_meter.sv
// ---------------------------------------------------------------------------
// rx_halfwave_meter
//   Receive-side meter for the DAC->ADC loopback path. A hysteresis
//   comparator tracks the polarity of the sampled stream; every polarity
//   crossing reports the peak magnitude and length of the half-wave that just
//   ended, checks that length against exp_half +/- tol, and a half-wave that
//   runs past 2*exp_half + tol samples is flagged as loss of signal.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous reset, active high
//   bus  rx_halfwave_meter_if.slave: sample stream in, measurements out
//        (all outputs registered, valid one clk after the ce sample)
// ---------------------------------------------------------------------------
module rx_halfwave_meter #(
    parameter int W          = 12,
    parameter bit OFFSET_BIN = 1'b1,
    parameter int HYST       = 16,
    parameter int PW         = 12,
    parameter int NW         = 8
) (
    input  logic                clk,
    input  logic                rst,
    rx_halfwave_meter_if.slave  bus
);
    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] POS  = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;

    localparam logic signed [W-1:0] HYST_P  = W'(HYST);
    localparam logic signed [W-1:0] HYST_N  = -HYST_P;
    localparam logic [PW-1:0]       CNT_MAX = '1;
    localparam logic [W-2:0]        MAG_MAX = '1;

    logic [1:0]    state;
    logic [PW-1:0] cnt;     // samples since the last crossing, excluding it
    logic [W-2:0]  peak;    // running max |x| of the current half-wave

    // Sample conversion and saturated magnitude. Only -2^(W-1) negates to a
    // value with the MSB still set, so that bit selects the clamp.
    logic signed [W-1:0] x;
    logic        [W-1:0] mag_full;
    logic        [W-2:0] mag;

    assign x        = OFFSET_BIN ? $signed({~bus.din[W-1], bus.din[W-2:0]})
                                 : $signed(bus.din);
    assign mag_full = x[W-1] ? -x : x;
    assign mag      = mag_full[W-1] ? MAG_MAX : mag_full[W-2:0];

    logic is_hi, is_lo, crossing;
    assign is_hi    = (x >= HYST_P);
    assign is_lo    = (x <= HYST_N);
    assign crossing = ((state == POS) && is_lo) || ((state == NEG) && is_hi);

    logic [PW-1:0] cnt_inc;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + PW'(1);

    // Period check: cnt_inc is the half-period reported on this crossing.
    logic signed [PW:0] diff;
    logic        [PW:0] adiff;
    logic               mismatch;
    assign diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, bus.exp_half});
    assign adiff    = diff[PW] ? $unsigned(-diff) : $unsigned(diff);
    assign mismatch = (adiff > {1'b0, bus.tol});

    // Loss of signal once the running half-wave reaches sat(2*exp_half + tol).
    logic [PW+1:0] los_raw;
    logic [PW-1:0] los_lim;
    logic [PW:0]   cnt_p1;
    logic          los;
    assign los_raw = {1'b0, bus.exp_half, 1'b0} + {2'b00, bus.tol};
    assign los_lim = (los_raw > {2'b00, CNT_MAX}) ? CNT_MAX : los_raw[PW-1:0];
    assign cnt_p1  = {1'b0, cnt} + (PW+1)'(1);
    assign los     = bus.lock && (cnt_p1 == {1'b0, los_lim});

    logic err_now;
    assign err_now = bus.ce && ((state == POS) || (state == NEG)) &&
                     (crossing ? (bus.lock && mismatch) : los);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            cnt          <= '0;
            peak         <= '0;
            bus.RXP      <= 1'b0;
            bus.RXN      <= 1'b0;
            bus.AMP      <= '0;
            bus.half_per <= '0;
            bus.N_RXPN   <= '0;
            bus.lock     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_cnt  <= '0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the
            // same block overrides them, so pulses are low unless set below.
            bus.RXP <= 1'b0;
            bus.RXN <= 1'b0;
            bus.err <= err_now;

            if (bus.ce) begin
                case (state)
                    INIT: begin
                        peak <= mag;
                        cnt  <= '0;
                        if (is_hi)      state <= POS;
                        else if (is_lo) state <= NEG;
                    end
                    POS, NEG: begin
                        if (crossing) begin
                            bus.RXP      <= (state == NEG);
                            bus.RXN      <= (state == POS);
                            state        <= (state == POS) ? NEG : POS;
                            bus.AMP      <= peak;   // crossing sample belongs to the next half
                            peak         <= mag;
                            bus.half_per <= cnt_inc;
                            cnt          <= '0;
                            bus.N_RXPN   <= bus.N_RXPN + NW'(1);
                            bus.lock     <= 1'b1;
                        end else if (los) begin
                            state    <= INIT;
                            bus.lock <= 1'b0;
                            cnt      <= '0;
                            peak     <= mag;
                        end else begin
                            cnt <= cnt_inc;
                            if (mag > peak) peak <= mag;
                        end
                    end
                    default: state <= INIT;
                endcase
            end

            if (bus.clr_err)
                bus.err_cnt <= {7'd0, err_now};
            else if (err_now && (bus.err_cnt != 8'hFF))
                bus.err_cnt <= bus.err_cnt + 8'd1;
        end
    end
endmodule
